// File: rtl/ga_int_gen_plus.sv
// Raster interrupt generator: periodic 52-line interrupt plus programmable line-match (PRI) interrupt.
// Latency: INT asserts one CLK after the sample tick that carries the qualifying HSYNC fall.
// Backpressure: none; INT stays asserted until INTack, a GA clear write, a PRI disable or RESET.
//
// Ports:
//   CLK, RESET        system clock, synchronous active-high reset
//   CE_4, phase       sync inputs are sampled only when CE_4 is high and phase == 2
//   crtc_hs, crtc_vs  CRTC sync outputs
//   WE, D             gate-array register write (0b10x1xxxx clears the periodic counter)
//   pri_we, pri_d     PRI register write, {enable, line}
//   INTack            Z80 interrupt acknowledge
//   INT, int_src      interrupt request and the source the next ack will clear (1 = PRI)
//   line_cnt          HSYNC falls since the last VSYNC rise (saturating)
//   irq_cnt           periodic line counter
module ga_int_gen_plus #(
   parameter int LINES_PER_INT = 52,
   parameter int CNT_W         = 6,
   parameter int VS_DELAY      = 2,
   parameter int LINE_W        = 9
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CE_4,
   input  logic [1:0]        phase,
   input  logic              crtc_hs,
   input  logic              crtc_vs,
   input  logic              WE,
   input  logic [7:0]        D,
   input  logic              pri_we,
   input  logic [LINE_W:0]   pri_d,
   input  logic              INTack,
   output logic              INT,
   output logic              int_src,
   output logic [LINE_W-1:0] line_cnt,
   output logic [CNT_W-1:0]  irq_cnt
);

   localparam logic [CNT_W-1:0]  WRAP_VAL = CNT_W'(LINES_PER_INT - 1);
   localparam logic [LINE_W-1:0] LINE_MAX = '1;

   // registered state
   logic                old_hs;
   logic                old_vs;
   logic [VS_DELAY-1:0] vs_dly;
   logic                per_pend;
   logic                pri_pend;
   logic [LINE_W:0]     pri_reg;

   // decoded events
   logic                tick;
   logic                hs_fall;
   logic                vs_rise;
   logic                pri_en;
   logic [LINE_W-1:0]   pri_line;
   logic                ga_clr;
   logic                ack_pri;
   logic                ack_per;

   // next-state values
   logic [CNT_W-1:0]    irq_nxt;
   logic [VS_DELAY-1:0] dly_nxt;
   logic                per_set;
   logic                per_nxt;
   logic [LINE_W-1:0]   line_nxt;
   logic                pri_match;
   logic                pri_nxt;

   assign tick     = CE_4 && (phase == 2'd2);
   assign hs_fall  = tick && old_hs && !crtc_hs;
   assign vs_rise  = tick && !old_vs && crtc_vs;
   assign pri_en   = pri_reg[LINE_W];
   assign pri_line = pri_reg[LINE_W-1:0];
   assign ga_clr   = WE && (D[7:6] == 2'b10) && D[4];

   // A single ack clears only one source; the PRI line interrupt is serviced first.
   assign ack_pri  = INTack && pri_pend;
   assign ack_per  = INTack && !pri_pend && per_pend;

   // Periodic counter and VSYNC resync delay line
   always_comb begin
      irq_nxt = irq_cnt;
      dly_nxt = vs_dly;
      per_set = 1'b0;
      if (hs_fall) begin
         irq_nxt = irq_cnt + CNT_W'(1);
         dly_nxt = vs_dly << 1;
         if (irq_cnt == WRAP_VAL) begin
            irq_nxt = '0;
            per_set = !pri_en;
         end
         // Resync uses the delay bit as it stood before this shift. Only a counter
         // already past half a period (MSB set) raises an interrupt on resync, so a
         // recently serviced interrupt is not followed by a second one too soon.
         if (vs_dly[VS_DELAY-1]) begin
            irq_nxt = '0;
            if (irq_cnt[CNT_W-1] && !pri_en) begin
               per_set = 1'b1;
            end
         end
      end
      // A new VSYNC restarts the delay line even if a shift happens on the same tick.
      if (vs_rise) begin
         dly_nxt = VS_DELAY'(1);
      end
      // The ack spacing bit is cleared on the value after this tick's increment.
      if (ack_per) begin
         irq_nxt[CNT_W-1] = 1'b0;
      end
      if (ga_clr) begin
         irq_nxt = '0;
      end
   end

   // Pending flag: ack clear < event set < GA clear
   always_comb begin
      per_nxt = per_pend;
      if (ack_per) begin
         per_nxt = 1'b0;
      end
      if (per_set) begin
         per_nxt = 1'b1;
      end
      if (ga_clr) begin
         per_nxt = 1'b0;
      end
   end

   // Frame line counter and PRI compare
   always_comb begin
      line_nxt  = line_cnt;
      pri_match = 1'b0;
      if (vs_rise) begin
         line_nxt = '0;
      end else if (hs_fall && (line_cnt != LINE_MAX)) begin
         // Matching only on a real increment keeps a saturated counter from
         // re-triggering the last line every HSYNC.
         line_nxt  = line_cnt + LINE_W'(1);
         pri_match = pri_en && (line_nxt == pri_line) && (pri_line != '0);
      end
   end

   // PRI pending: ack clear < match set < disabling write
   always_comb begin
      pri_nxt = pri_pend;
      if (ack_pri) begin
         pri_nxt = 1'b0;
      end
      if (pri_match) begin
         pri_nxt = 1'b1;
      end
      if (pri_we && !pri_d[LINE_W]) begin
         pri_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         old_hs   <= 1'b0;
         old_vs   <= 1'b0;
         vs_dly   <= '0;
         irq_cnt  <= '0;
         per_pend <= 1'b0;
         line_cnt <= '0;
         pri_pend <= 1'b0;
         pri_reg  <= '0;
      end else begin
         if (tick) begin
            old_hs <= crtc_hs;
            old_vs <= crtc_vs;
         end
         vs_dly   <= dly_nxt;
         irq_cnt  <= irq_nxt;
         per_pend <= per_nxt;
         line_cnt <= line_nxt;
         pri_pend <= pri_nxt;
         if (pri_we) begin
            pri_reg <= pri_d;
         end
      end
   end

   assign INT     = per_pend | pri_pend;
   assign int_src = pri_pend;

endmodule

// File: tb/tb_ga_int_gen_plus.sv
module tb_ga_int_gen_plus;

   localparam int LW = 9;
   localparam int CW = 6;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          CE_4;
   logic [1:0]    phase;
   logic          crtc_hs;
   logic          crtc_vs;
   logic          WE;
   logic [7:0]    D;
   logic          pri_we;
   logic [LW:0]   pri_d;
   logic          INTack;
   logic          INT;
   logic          int_src;
   logic [LW-1:0] line_cnt;
   logic [CW-1:0] irq_cnt;

   always #5 CLK = ~CLK;

   ga_int_gen_plus #(
      .LINES_PER_INT(52),
      .CNT_W        (CW),
      .VS_DELAY     (2),
      .LINE_W       (LW)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .CE_4    (CE_4),
      .phase   (phase),
      .crtc_hs (crtc_hs),
      .crtc_vs (crtc_vs),
      .WE      (WE),
      .D       (D),
      .pri_we  (pri_we),
      .pri_d   (pri_d),
      .INTack  (INTack),
      .INT     (INT),
      .int_src (int_src),
      .line_cnt(line_cnt),
      .irq_cnt (irq_cnt)
   );

   typedef enum int {OP_NOP, OP_RST, OP_HSN, OP_VS, OP_ACK, OP_GA, OP_PRI, OP_BADPH, OP_HSACK} op_t;

   typedef struct {
      op_t  op;
      int   arg;
      logic e_int;
      logic e_src;
      int   e_irq;
      int   e_line;
   } vec_t;

   typedef struct {
      logic e_int;
      logic e_src;
      int   e_irq;
      int   e_line;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input op_t op, input int arg, input logic ei, input logic es,
                      input int ec, input int el);
      vec_t v;
      v.op = op; v.arg = arg; v.e_int = ei; v.e_src = es; v.e_irq = ec; v.e_line = el;
      vecs.push_back(v);
   endtask

   task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL v%0d %s actual=%0d required=%0d", idx, nm, act, exp);
      end
   endtask

   // One CLK of drive, starting and ending on a falling edge.
   task automatic cyc(input logic ce, input logic [1:0] ph, input logic hs, input logic vs, input logic ack);
      CE_4 = ce; phase = ph; crtc_hs = hs; crtc_vs = vs; INTack = ack;
      @(negedge CLK);
      CE_4 = 1'b0; phase = 2'd0; INTack = 1'b0;
   endtask

   task automatic hs_pulse(input logic ack_on_fall);
      cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0, ack_on_fall);
   endtask

   task automatic apply(input vec_t v);
      case (v.op)
         OP_RST: begin
            RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
         end
         OP_HSN: for (int k = 0; k < v.arg; k++) hs_pulse(1'b0);
         OP_HSACK: hs_pulse(1'b1);
         OP_VS: begin
            cyc(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
            cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
         end
         OP_ACK: cyc(1'b0, 2'd0, crtc_hs, crtc_vs, 1'b1);
         OP_GA: begin
            WE = 1'b1; D = 8'(v.arg); @(negedge CLK); WE = 1'b0;
         end
         OP_PRI: begin
            pri_we = 1'b1; pri_d = (LW+1)'(v.arg); @(negedge CLK); pri_we = 1'b0;
         end
         OP_BADPH: begin
            // HSYNC drops only on non-sampling cycles: must not count.
            cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
         end
         default: @(negedge CLK);
      endcase
   endtask

   initial begin
      exp_t e;
      RESET = 1'b1; CE_4 = 1'b0; phase = 2'd0; crtc_hs = 1'b0; crtc_vs = 1'b0;
      WE = 1'b0; D = 8'h00; pri_we = 1'b0; pri_d = '0; INTack = 1'b0;

      //   op        arg  INT src irq line
      add(OP_NOP,     0,  0, 0,  0,   0);
      add(OP_BADPH,   0,  0, 0,  0,   0);
      add(OP_HSN,    51,  0, 0, 51,  51);
      add(OP_HSN,     1,  1, 0,  0,  52);   // 52nd fall
      add(OP_HSN,     3,  1, 0,  3,  55);
      add(OP_ACK,     0,  0, 0,  3,  55);   // ack at fall 55
      add(OP_HSN,    48,  0, 0, 51, 103);
      add(OP_HSN,     1,  1, 0,  0, 104);   // fall 104
      add(OP_ACK,     0,  0, 0,  0, 104);
      add(OP_HSN,    40,  0, 0, 40, 144);
      add(OP_VS,      0,  0, 0, 40,   0);
      add(OP_HSN,     1,  0, 0, 41,   1);
      add(OP_HSN,     1,  1, 0,  0,   2);   // resync with MSB set
      add(OP_ACK,     0,  0, 0,  0,   2);
      add(OP_HSN,    20,  0, 0, 20,  22);
      add(OP_VS,      0,  0, 0, 20,   0);
      add(OP_HSN,     1,  0, 0, 21,   1);
      add(OP_HSN,     1,  0, 0,  0,   2);   // resync, MSB clear: no INT
      add(OP_HSN,    10,  0, 0, 10,  12);
      add(OP_ACK,     0,  0, 0, 10,  12);   // nothing pending: ignored
      add(OP_HSN,     1,  0, 0, 11,  13);
      add(OP_HSN,    41,  1, 0,  0,  54);
      add(OP_HSN,    10,  1, 0, 10,  64);
      add(OP_ACK,     0,  0, 0, 10,  64);   // MSB already 0
      add(OP_HSN,     1,  0, 0, 11,  65);
      add(OP_HSN,    41,  1, 0,  0, 106);
      add(OP_HSN,    33,  1, 0, 33, 139);
      add(OP_ACK,     0,  0, 0,  1, 139);   // 33 -> 1
      add(OP_VS,      0,  0, 0,  1,   0);
      add(OP_HSN,     1,  0, 0,  2,   1);
      add(OP_HSN,     1,  0, 0,  0,   2);   // resync INT suppressed
      add(OP_PRI,   612,  0, 0,  0,   2);   // {1,100}
      add(OP_VS,      0,  0, 0,  0,   0);
      add(OP_HSN,    99,  0, 0, 45,  99);   // wrap at fall 54 raises nothing
      add(OP_HSN,     1,  1, 1, 46, 100);
      add(OP_HSN,    60,  1, 1,  2, 160);
      add(OP_ACK,     0,  0, 0,  2, 160);   // no periodic pending behind it
      add(OP_PRI,   100,  0, 0,  2, 160);   // {0,100}
      add(OP_HSN,    49,  0, 0, 51, 209);
      add(OP_HSN,     1,  1, 0,  0, 210);
      add(OP_HSN,    51,  1, 0, 51, 261);
      add(OP_HSACK,   0,  1, 0,  0, 262);   // wrap and ack in same CLK
      add(OP_HSN,    32,  1, 0, 32, 294);
      add(OP_HSACK,   0,  0, 0,  1, 295);   // ack clears MSB of post-increment 33
      add(OP_HSN,    51,  1, 0,  0, 346);
      add(OP_PRI,   862,  1, 0,  0, 346);   // {1,350}
      add(OP_HSN,     4,  1, 1,  4, 350);
      add(OP_GA,   8'h80, 1, 1,  4, 350);   // bit 4 clear: ignored
      add(OP_GA,   8'hD0, 1, 1,  4, 350);   // wrong function: ignored
      add(OP_GA,   8'h90, 1, 1,  0, 350);   // periodic cleared, PRI kept
      add(OP_ACK,     0,  0, 0,  0, 350);
      add(OP_HSN,     5,  0, 0,  5, 355);
      add(OP_PRI,   872,  0, 0,  5, 355);   // {1,360}
      add(OP_HSN,     5,  1, 1, 10, 360);
      add(OP_PRI,   360,  0, 0, 10, 360);   // disable clears PRI pending
      add(OP_HSN,    41,  0, 0, 51, 401);
      add(OP_HSN,     1,  1, 0,  0, 402);
      add(OP_PRI,   917,  1, 0,  0, 402);   // {1,405}
      add(OP_HSN,     3,  1, 1,  3, 405);   // both pending
      add(OP_ACK,     0,  1, 0,  3, 405);   // PRI acked first
      add(OP_ACK,     0,  0, 0,  3, 405);
      add(OP_RST,     0,  0, 0,  0,   0);   // mid-frame reset
      add(OP_HSN,    52,  1, 0,  0,  52);   // PRI reg was reset too
      add(OP_HSN,   460,  1, 0, 44, 511);   // line count saturates
      add(OP_HSN,     1,  1, 0, 45, 511);

      repeat (3) @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         e.e_int = vecs[i].e_int; e.e_src = vecs[i].e_src;
         e.e_irq = vecs[i].e_irq; e.e_line = vecs[i].e_line;
         sb.push_back(e);
         apply(vecs[i]);
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL v%0d scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            chk(i, "INT",      32'(INT),      32'(e.e_int));
            chk(i, "int_src",  32'(int_src),  32'(e.e_src));
            chk(i, "irq_cnt",  32'(irq_cnt),  32'(e.e_irq));
            chk(i, "line_cnt", 32'(line_cnt), 32'(e.e_line));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
